usr_counted: RTL

- Parametrised universal shift register, successor to the fixed 4-bit load/shift/hold register.
- Adds a WIDTH parameter, four fill modes (serial, rotate, arithmetic, zero) and a counted multi-step shift engine with BUSY/DONE handshake.
- Used for shift-count and normalise paths: the controller issues START with a count and waits for DONE.
- Bit 0 is the MSB, matching PDP-10 bit numbering throughout.

---
 rtl/usr_pkg.sv | 6 +
 rtl/usr_shift_step.sv | 18 +
 rtl/usr_counted.sv | 85 ++++++++
 3 files changed

// File: rtl/usr_pkg.sv
// usr_pkg: shared op, fill and state encodings for the universal shift register
package usr_pkg;
    typedef enum logic [1:0] {SEL_LOAD, SEL_SHR, SEL_SHL, SEL_HOLD} sel_t;
    typedef enum logic [1:0] {FILL_SERIAL, FILL_ROT, FILL_ARITH, FILL_ZERO} fill_t;
    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;
endpackage

// File: rtl/usr_shift_step.sv
// usr_shift_step: one-position shift with fill selection; bit 0 is the MSB
module usr_shift_step import usr_pkg::*; #(
    parameter int WIDTH = 36
) (
    input  logic [0:WIDTH-1] q,
    input  logic             dir,
    input  fill_t            fill,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [0:WIDTH-1] q_next,
    output logic             bit_out
);
    logic fill_r, fill_l;
    assign fill_r  = fill == FILL_SERIAL ? sin_l : fill == FILL_ROT ? q[WIDTH-1] : fill == FILL_ARITH ? q[0] : 1'b0;
    assign fill_l  = fill == FILL_SERIAL ? sin_r : fill == FILL_ROT ? q[0] : 1'b0;
    assign q_next  = dir ? {q[1:WIDTH-1], fill_l} : {fill_r, q[0:WIDTH-2]};
    assign bit_out = dir ? q[0] : q[WIDTH-1];
endmodule

// File: rtl/usr_counted.sv
// usr_counted: universal shift register with a counted multi-step shift engine
module usr_counted import usr_pkg::*; #(
    parameter int WIDTH = 36,
    parameter int CW    = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [1:0]       SEL,
    input  logic [1:0]       FILL,
    input  logic             SIN_L,
    input  logic             SIN_R,
    input  logic [0:WIDTH-1] D,
    input  logic             START,
    input  logic             DIR,
    input  logic [CW-1:0]    COUNT,
    output logic [0:WIDTH-1] Q,
    output logic             SOUT,
    output logic             BUSY,
    output logic             DONE
);
    state_t          state;
    logic            dir_l;
    fill_t           fill_l;
    logic [CW-1:0]   remaining;
    sel_t            sel;
    logic            step_dir;
    fill_t           step_fill;
    logic [0:WIDTH-1] q_next;
    logic            bit_out;

    assign sel       = sel_t'(SEL);
    // The counted path uses the operands latched at START; the direct path uses live inputs.
    assign step_dir  = state == ST_SHIFT ? dir_l : sel == SEL_SHL;
    assign step_fill = state == ST_SHIFT ? fill_l : fill_t'(FILL);

    usr_shift_step #(.WIDTH(WIDTH)) u_step (
        .q(Q),
        .dir(step_dir),
        .fill(step_fill),
        .sin_l(SIN_L),
        .sin_r(SIN_R),
        .q_next(q_next),
        .bit_out(bit_out)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= ST_IDLE;
            dir_l     <= 1'b0;
            fill_l    <= FILL_SERIAL;
            remaining <= '0;
            Q         <= '0;
            SOUT      <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (state == ST_SHIFT) begin
                Q         <= q_next;
                SOUT      <= bit_out;
                remaining <= remaining - 1'b1;
                if (remaining == CW'(1)) begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b1;
                end
            end else if (START) begin
                dir_l     <= DIR;
                fill_l    <= fill_t'(FILL);
                remaining <= COUNT;
                if (COUNT != '0) begin
                    state <= ST_SHIFT;
                    BUSY  <= 1'b1;
                end else begin
                    DONE  <= 1'b1;
                end
            end else if (sel == SEL_LOAD) begin
                Q <= D;
            end else if (sel != SEL_HOLD) begin
                Q    <= q_next;
                SOUT <= bit_out;
            end
        end
    end
endmodule
